high_speed_bus_ecc_decoder: RTL and testbench

Receive-side SECDED checker/corrector for the 39-bit high-speed bus codeword. It sits directly downstream of high_speed_bus_ecc and consumes its data_out. It recomputes the check bits, corrects single-bit errors and flags double-bit or uncorrectable errors. Results leave through a 2-stage elastic valid/ready pipeline, with saturating error counters and a sticky interrupt.

---
 rtl/high_speed_bus_ecc_decoder.sv | 121 ++++++++++++
 tb/tb_high_speed_bus_ecc_decoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/high_speed_bus_ecc_decoder.sv
// high_speed_bus_ecc_decoder: SECDED check/correct for the 39-bit bus codeword, 2-stage elastic pipeline
module high_speed_bus_ecc_decoder #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [38:0]          in_codeword,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic                 out_corrected,
    output logic                 out_uncorrectable,
    output logic [5:0]           out_syndrome,
    input  logic                 cnt_clear,
    output logic [CNT_WIDTH-1:0] corr_count,
    output logic [CNT_WIDTH-1:0] uncorr_count,
    output logic                 err_irq
);
    // Column code of data bit idx: the idx-th non-power-of-two integer from 3 upward
    function automatic logic [5:0] h_code(input int idx);
        int k;
        logic [5:0] r;
        k = 0;
        r = '0;
        for (int n = 3; n < 39; n++) begin
            if ((n & (n - 1)) != 0) begin
                if (k == idx) r = 6'(n);
                k++;
            end
        end
        return r;
    endfunction

    logic        s1_valid;
    logic [31:0] s1_data;
    logic [5:0]  s1_syn;
    logic        s1_q;
    logic [5:0]  c_re;
    logic [5:0]  syn;
    logic        q;
    logic [31:0] fix;
    logic        corr;
    logic        uncorr;
    logic        s2_adv;
    logic        hs;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;
    assign hs       = out_valid && out_ready;

    // Recompute check bits on the incoming word and form syndrome and overall parity
    always_comb begin
        c_re = '0;
        for (int i = 0; i < 32; i++) c_re = c_re ^ (in_codeword[i] ? h_code(i) : 6'd0);
        syn = in_codeword[37:32] ^ c_re;
        q   = ^in_codeword;
    end

    // Classify the stage-1 word; a power-of-two or zero syndrome with q=1 is a check/parity bit hit
    always_comb begin
        fix = '0;
        for (int i = 0; i < 32; i++) fix[i] = s1_q && (s1_syn == h_code(i));
        corr   = s1_q && (((s1_syn & (s1_syn - 6'd1)) == 6'd0) || (|fix));
        uncorr = s1_q ? !corr : (s1_syn != 6'd0);
    end

    // Stage 1: capture accepted codeword data with its syndrome and parity
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_syn   <= '0;
            s1_q     <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_codeword[31:0];
                s1_syn  <= syn;
                s1_q    <= q;
            end
        end
    end

    // Stage 2: registered corrected output, held while downstream stalls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_corrected     <= 1'b0;
            out_uncorrectable <= 1'b0;
            out_syndrome      <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data          <= s1_data ^ fix;
                out_corrected     <= corr;
                out_uncorrectable <= uncorr;
                out_syndrome      <= s1_syn;
            end
        end
    end

    // Saturating error counters and sticky interrupt; clear wins over a same-cycle update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            corr_count   <= '0;
            uncorr_count <= '0;
            err_irq      <= 1'b0;
        end else if (cnt_clear) begin
            corr_count   <= '0;
            uncorr_count <= '0;
            err_irq      <= 1'b0;
        end else if (hs) begin
            if (out_corrected && !(&corr_count)) corr_count <= corr_count + CNT_WIDTH'(1);
            if (out_uncorrectable && !(&uncorr_count)) uncorr_count <= uncorr_count + CNT_WIDTH'(1);
            if (out_uncorrectable) err_irq <= 1'b1;
        end
    end
endmodule

// File: tb/tb_high_speed_bus_ecc_decoder.sv
// tb_high_speed_bus_ecc_decoder: directed self-checking bench for the SECDED decoder
module tb_high_speed_bus_ecc_decoder;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [38:0]  in_codeword = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [31:0]  out_data;
    logic         out_corrected;
    logic         out_uncorrectable;
    logic [5:0]   out_syndrome;
    logic         cnt_clear = 1'b0;
    logic [W-1:0] corr_count;
    logic [W-1:0] uncorr_count;
    logic         err_irq;

    int errors = 0;
    int checks = 0;

    high_speed_bus_ecc_decoder #(.CNT_WIDTH(W)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_codeword(in_codeword),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_corrected(out_corrected),
        .out_uncorrectable(out_uncorrectable),
        .out_syndrome(out_syndrome),
        .cnt_clear(cnt_clear),
        .corr_count(corr_count),
        .uncorr_count(uncorr_count),
        .err_irq(err_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] d,
                           input logic c, input logic u, input logic [5:0] s);
        check({tag, ".valid"}, 64'(out_valid), 64'(v));
        check({tag, ".data"}, 64'(out_data), 64'(d));
        check({tag, ".corr"}, 64'(out_corrected), 64'(c));
        check({tag, ".uncorr"}, 64'(out_uncorrectable), 64'(u));
        check({tag, ".syn"}, 64'(out_syndrome), 64'(s));
    endtask

    task automatic chk_cnt(input string tag, input logic [W-1:0] cc, input logic [W-1:0] uc, input logic irq);
        check({tag, ".corr_count"}, 64'(corr_count), 64'(cc));
        check({tag, ".uncorr_count"}, 64'(uncorr_count), 64'(uc));
        check({tag, ".err_irq"}, 64'(err_irq), 64'(irq));
    endtask

    task automatic send(input logic [38:0] cw);
        in_valid = 1'b1;
        in_codeword = cw;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_codeword = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        @(posedge clk);
        #1;
    endtask

    // Builds a clean codeword so the stream can carry distinct non-zero data
    function automatic logic [38:0] enc(input logic [31:0] d);
        logic [5:0] c;
        int n;
        c = '0;
        n = 3;
        for (int i = 0; i < 32; i++) begin
            if ((n & (n - 1)) == 0) n++;
            if (d[i]) c = c ^ 6'(n);
            n++;
        end
        return {^{d, c}, c, d};
    endfunction

    logic [5:0]  h_tab [10];
    logic [31:0] sd [10];
    logic [38:0] scw [10];

    initial begin
        int idx, oidx, cyc;
        logic held, saw_block, acc, hs;
        logic [31:0] held_d;
        logic [5:0] held_s;
        h_tab = '{6'd3, 6'd5, 6'd6, 6'd7, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14};
        for (int k = 0; k < 10; k++) begin
            sd[k] = 32'h1111_1111 * 32'(k + 1);
            scw[k] = enc(sd[k]) ^ (39'h1 << k);
        end

        #3;
        chk_out("rst", 1'b0, 32'h0, 1'b0, 1'b0, 6'h0);
        check("rst.in_ready", 64'(in_ready), 64'd1);
        chk_cnt("rst", 2'd0, 2'd0, 1'b0);
        #10 reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst.in_ready", 64'(in_ready), 64'd1);

        send(39'h0);
        chk_out("clean", 1'b1, 32'h0, 1'b0, 1'b0, 6'h00);
        drain();
        check("clean.after", 64'(out_valid), 64'd0);
        chk_cnt("clean", 2'd0, 2'd0, 1'b0);

        send(39'h00_0000_0001);
        chk_out("d0", 1'b1, 32'h0, 1'b1, 1'b0, 6'h03);
        drain();
        chk_cnt("d0", 2'd1, 2'd0, 1'b0);

        send(39'h01_0000_0000);
        chk_out("c0", 1'b1, 32'h0, 1'b1, 1'b0, 6'h01);
        drain();
        chk_cnt("c0", 2'd2, 2'd0, 1'b0);

        send(39'h40_0000_0000);
        chk_out("par", 1'b1, 32'h0, 1'b1, 1'b0, 6'h00);
        drain();
        chk_cnt("par", 2'd3, 2'd0, 1'b0);

        send(39'h00_0000_0003);
        chk_out("dbl", 1'b1, 32'h3, 1'b0, 1'b1, 6'h06);
        drain();
        chk_cnt("dbl", 2'd3, 2'd1, 1'b1);

        send(39'h60_0000_0008);
        chk_out("range", 1'b1, 32'h8, 1'b0, 1'b1, 6'h27);
        drain();
        chk_cnt("range", 2'd3, 2'd2, 1'b1);

        cnt_clear = 1'b1;
        @(posedge clk);
        #1;
        cnt_clear = 1'b0;
        chk_cnt("clear", 2'd0, 2'd0, 1'b0);

        idx = 0;
        oidx = 0;
        cyc = 0;
        held = 1'b0;
        saw_block = 1'b0;
        held_d = '0;
        held_s = '0;
        while (oidx < 10 && cyc < 60) begin
            in_valid = (idx < 10);
            in_codeword = (idx < 10) ? scw[idx] : 39'h0;
            out_ready = !(cyc >= 3 && cyc <= 6);
            @(negedge clk);
            acc = in_valid && in_ready;
            hs = out_valid && out_ready;
            if (!in_ready) saw_block = 1'b1;
            if (held) begin
                check($sformatf("stall%0d.data", cyc), 64'(out_data), 64'(held_d));
                check($sformatf("stall%0d.syn", cyc), 64'(out_syndrome), 64'(held_s));
            end
            if (hs) begin
                chk_out($sformatf("s%0d", oidx), 1'b1, sd[oidx], 1'b1, 1'b0, h_tab[oidx]);
                oidx++;
            end
            held = out_valid && !out_ready;
            held_d = out_data;
            held_s = out_syndrome;
            @(posedge clk);
            #1;
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream.count", 64'(oidx), 64'd10);
        check("stream.accepted", 64'(idx), 64'd10);
        check("stream.in_ready_dropped", 64'(saw_block), 64'd1);
        drain();
        check("stream.drained", 64'(out_valid), 64'd0);
        chk_cnt("sat", 2'd3, 2'd0, 1'b0);

        send(39'h00_0000_0003);
        drain();
        chk_cnt("unc1", 2'd3, 2'd1, 1'b1);
        send(39'h00_0000_0003);
        check("clr_hs.valid", 64'(out_valid), 64'd1);
        cnt_clear = 1'b1;
        @(posedge clk);
        #1;
        cnt_clear = 1'b0;
        check("clr_hs.out_valid", 64'(out_valid), 64'd0);
        chk_cnt("clr_hs", 2'd0, 2'd0, 1'b0);

        in_valid = 1'b1;
        in_codeword = 39'h00_0000_0001;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("mid.valid", 64'(out_valid), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst.out_valid", 64'(out_valid), 64'd0);
        check("mid_rst.in_ready", 64'(in_ready), 64'd1);
        chk_cnt("mid_rst", 2'd0, 2'd0, 1'b0);
        in_valid = 1'b0;
        #10 reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("after_rst.out_valid", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
